clk_count_mod: RTL and testbench

- Parametrised modulo counter: next generation of the clock-digit counters (seconds/minutes/hours).
- Counts up or down over the range MIN_VAL..MAX_VAL. Supports wrap or saturate mode, synchronous load (time-set) with range clamping, and a clear.
- Emits carry/borrow strobes for chaining into the next stage (sec -> min -> hr).
- One instance serves as the 0..59 minute/second digit or the 1..12 / 0..23 hour digit.

---
 rtl/clk_count_mod.sv | 173 +++++++++++++++++
 tb/tb_clk_count_mod.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/clk_count_mod.sv
// clk_count_mod: up/down modulo counter for clock digits with clamped load and carry/borrow chaining.
// Define CLK_COUNT_MOD_BCD_EN to add registered bcd_tens/bcd_units digit outputs (requires MAX_VAL <= 99).
module clk_count_mod #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 59,
    parameter bit          WRAP    = 1'b1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_en,
    input  logic             count_dn,
    output logic [WIDTH-1:0] cnt,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             at_bound,
    output logic             load_err
`ifdef CLK_COUNT_MOD_BCD_EN
    ,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_units
`endif
);

    localparam logic [WIDTH-1:0] MIN_C = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

    if (MIN_VAL >= MAX_VAL) begin : g_bad_order
        $error("clk_count_mod: MIN_VAL must be below MAX_VAL");
    end
    if (64'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_width
        $error("clk_count_mod: MAX_VAL does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             at_bound_q, at_bound_d;
    logic             load_err_q, load_err_d;
    logic             at_max_s, at_min_s, step_s;
    logic             below_s, above_s;
    logic             carry_s, borrow_s;

    // Range checks drop out entirely when a bound coincides with the type limit.
    if (MIN_VAL == 0) begin : g_no_below
        assign below_s = 1'b0;
    end else begin : g_below
        assign below_s = (load_val < MIN_C);
    end
    if (64'(MAX_VAL) == ((64'd1 << WIDTH) - 64'd1)) begin : g_no_above
        assign above_s = 1'b0;
    end else begin : g_above
        assign above_s = (load_val > MAX_C);
    end

    // Bound detection and zero-latency chaining strobes.
    always_comb begin
        at_max_s = (cnt_q == MAX_C);
        at_min_s = (cnt_q == MIN_C);
        step_s   = count_en & ~clr & ~load & ~rst;
        carry_s  = step_s & ~count_dn & at_max_s & WRAP;
        borrow_s = step_s &  count_dn & at_min_s & WRAP;
    end

    // Next-state count with clr > load > count_en priority; rst is applied in the register block.
    always_comb begin
        cnt_d      = cnt_q;
        load_err_d = 1'b0;
        if (clr) begin
            cnt_d = MIN_C;
        end else if (load) begin
            if (above_s) begin
                cnt_d      = MAX_C;
                load_err_d = 1'b1;
            end else if (below_s) begin
                cnt_d      = MIN_C;
                load_err_d = 1'b1;
            end else begin
                cnt_d = load_val;
            end
        end else if (count_en) begin
            if (count_dn) begin
                if (!at_min_s) begin
                    cnt_d = cnt_q - ONE_C;
                end else if (WRAP) begin
                    cnt_d = MAX_C;
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                if (!at_max_s) begin
                    cnt_d = cnt_q + ONE_C;
                end else if (WRAP) begin
                    cnt_d = MIN_C;
                end else begin
                    cnt_d = cnt_q;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
        at_bound_d = count_dn ? (cnt_d == MIN_C) : (cnt_d == MAX_C);
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            cnt_q      <= MIN_C;
            at_bound_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            at_bound_q <= at_bound_d;
            load_err_q <= load_err_d;
        end
    end

    assign cnt        = cnt_q;
    assign at_bound   = at_bound_q;
    assign load_err   = load_err_q;
    assign carry_out  = carry_s;
    assign borrow_out = borrow_s;

`ifdef CLK_COUNT_MOD_BCD_EN
    if (MAX_VAL > 99) begin : g_bad_bcd
        $error("clk_count_mod: BCD outputs need MAX_VAL <= 99");
    end

    // Double-dabble conversion of a 0..99 value into {tens, units}.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [14:0] sh;
        sh = {8'd0, v};
        for (int i = 0; i < 7; i++) begin
            if (sh[10:7] >= 4'd5) begin
                sh[10:7] = sh[10:7] + 4'd3;
            end else begin
                sh[10:7] = sh[10:7];
            end
            if (sh[14:11] >= 4'd5) begin
                sh[14:11] = sh[14:11] + 4'd3;
            end else begin
                sh[14:11] = sh[14:11];
            end
            sh = sh << 1;
        end
        return sh[14:7];
    endfunction

    localparam logic [7:0] MIN_BCD_C = to_bcd(7'(MIN_VAL));

    logic [7:0] bcd_q, bcd_d;

    // Digits are derived from the next-state count so they stay aligned with cnt.
    always_comb begin
        bcd_d = to_bcd(7'(cnt_d));
    end

    // BCD digit register.
    always_ff @(posedge CLK) begin
        if (rst) begin
            bcd_q <= MIN_BCD_C;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_tens  = bcd_q[7:4];
    assign bcd_units = bcd_q[3:0];
`endif

endmodule

// File: tb/tb_clk_count_mod.sv
// Scoreboard bench for clk_count_mod: three instances (0..59 wrap, 1..12 wrap, 0..23 saturate).
module tb_clk_count_mod;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic T = 1'b1;
    localparam logic F = 1'b0;

    logic [2:0] rst_v, clr_v, load_v, en_v, dn_v;
    logic [7:0] lv;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [2:0] carry_v, borrow_v, bound_v, err_v;
`ifdef CLK_COUNT_MOD_BCD_EN
    logic [3:0] bt0, bu0, bt1, bu1, bt2, bu2;
`endif

    clk_count_mod #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(59), .WRAP(1'b1)) u0 (
        .CLK(CLK), .rst(rst_v[0]), .clr(clr_v[0]), .load(load_v[0]), .load_val(lv),
        .count_en(en_v[0]), .count_dn(dn_v[0]), .cnt(cnt0), .carry_out(carry_v[0]),
        .borrow_out(borrow_v[0]), .at_bound(bound_v[0]), .load_err(err_v[0])
`ifdef CLK_COUNT_MOD_BCD_EN
        , .bcd_tens(bt0), .bcd_units(bu0)
`endif
    );

    clk_count_mod #(.WIDTH(8), .MIN_VAL(1), .MAX_VAL(12), .WRAP(1'b1)) u1 (
        .CLK(CLK), .rst(rst_v[1]), .clr(clr_v[1]), .load(load_v[1]), .load_val(lv),
        .count_en(en_v[1]), .count_dn(dn_v[1]), .cnt(cnt1), .carry_out(carry_v[1]),
        .borrow_out(borrow_v[1]), .at_bound(bound_v[1]), .load_err(err_v[1])
`ifdef CLK_COUNT_MOD_BCD_EN
        , .bcd_tens(bt1), .bcd_units(bu1)
`endif
    );

    clk_count_mod #(.WIDTH(8), .MIN_VAL(0), .MAX_VAL(23), .WRAP(1'b0)) u2 (
        .CLK(CLK), .rst(rst_v[2]), .clr(clr_v[2]), .load(load_v[2]), .load_val(lv),
        .count_en(en_v[2]), .count_dn(dn_v[2]), .cnt(cnt2), .carry_out(carry_v[2]),
        .borrow_out(borrow_v[2]), .at_bound(bound_v[2]), .load_err(err_v[2])
`ifdef CLK_COUNT_MOD_BCD_EN
        , .bcd_tens(bt2), .bcd_units(bu2)
`endif
    );

    typedef struct { int id; int inst; logic carry; logic borrow; } comb_t;
    typedef struct { int id; int inst; logic [7:0] cnt; logic bound; logic err; } reg_t;

    comb_t comb_q[$];
    reg_t  reg_q[$];
    int    total = 0;
    int    bad = 0;
    int    step_id = 0;

    function automatic logic [7:0] cnt_of(input int i);
        case (i)
            0: return cnt0;
            1: return cnt1;
            default: return cnt2;
        endcase
    endfunction

`ifdef CLK_COUNT_MOD_BCD_EN
    function automatic logic [7:0] bcd_of(input int i);
        case (i)
            0: return {bt0, bu0};
            1: return {bt1, bu1};
            default: return {bt2, bu2};
        endcase
    endfunction
`endif

    task automatic chk(input string name, input int id, input int inst, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s step=%0d inst=%0d got=%0d want=%0d", name, id, inst, got, want);
        end
    endtask

    // One clock of stimulus on one instance; expectations are queued for the monitor.
    task automatic cyc(input int inst, input logic r, input logic c, input logic l, input logic [7:0] v,
                       input logic e, input logic d, input logic ex_c, input logic ex_b,
                       input logic [7:0] ex_cnt, input logic ex_bd, input logic ex_err);
        comb_t ci;
        reg_t  ri;
        rst_v = 3'b000; clr_v = 3'b000; load_v = 3'b000; en_v = 3'b000; dn_v = 3'b000;
        rst_v[inst] = r; clr_v[inst] = c; load_v[inst] = l; en_v[inst] = e; dn_v[inst] = d;
        lv = v;
        ci.id = step_id; ci.inst = inst; ci.carry = ex_c; ci.borrow = ex_b;
        ri.id = step_id; ri.inst = inst; ri.cnt = ex_cnt; ri.bound = ex_bd; ri.err = ex_err;
        comb_q.push_back(ci);
        reg_q.push_back(ri);
        step_id++;
        @(posedge CLK);
        #2;
    endtask

    // Monitor: strobes sampled mid-cycle, registered outputs just after the edge.
    initial begin
        comb_t ce;
        reg_t  re;
        forever begin
            @(negedge CLK);
            if (comb_q.size() > 0) begin
                ce = comb_q.pop_front();
                chk("carry_out", ce.id, ce.inst, int'(carry_v[ce.inst]), int'(ce.carry));
                chk("borrow_out", ce.id, ce.inst, int'(borrow_v[ce.inst]), int'(ce.borrow));
            end
            @(posedge CLK);
            #1;
            if (reg_q.size() > 0) begin
                re = reg_q.pop_front();
                chk("cnt", re.id, re.inst, int'(cnt_of(re.inst)), int'(re.cnt));
                chk("at_bound", re.id, re.inst, int'(bound_v[re.inst]), int'(re.bound));
                chk("load_err", re.id, re.inst, int'(err_v[re.inst]), int'(re.err));
`ifdef CLK_COUNT_MOD_BCD_EN
                chk("bcd", re.id, re.inst, int'(bcd_of(re.inst)),
                    ((int'(re.cnt) / 10) * 16) + (int'(re.cnt) % 10));
`endif
            end
        end
    end

    initial begin
        rst_v = 3'b111; clr_v = 3'b000; load_v = 3'b000; en_v = 3'b000; dn_v = 3'b000; lv = 8'd0;
        repeat (2) @(posedge CLK);
        #2;

        // 0..59 wrap: reset with count_en, wrap up, wrap down, clamp, priority, rst
        cyc(0, T, F, F, 8'd0,   T, F, F, F, 8'd0,  F, F);
        cyc(0, F, F, T, 8'd58,  F, F, F, F, 8'd58, F, F);
        cyc(0, F, F, F, 8'd0,   T, F, F, F, 8'd59, T, F);
        cyc(0, F, F, F, 8'd0,   T, F, T, F, 8'd0,  F, F);
        cyc(0, F, F, F, 8'd0,   T, T, F, T, 8'd59, F, F);
        cyc(0, F, F, T, 8'd75,  T, F, F, F, 8'd59, T, T);
        cyc(0, F, F, F, 8'd0,   F, F, F, F, 8'd59, T, F);
        cyc(0, F, T, T, 8'd30,  T, F, F, F, 8'd0,  F, F);
        cyc(0, F, F, T, 8'd200, F, F, F, F, 8'd59, T, T);
        cyc(0, T, F, F, 8'd0,   T, F, F, F, 8'd0,  F, F);
        cyc(0, F, F, T, 8'd47,  F, F, F, F, 8'd47, F, F);
        for (int k = 48; k <= 59; k++) begin
            cyc(0, F, F, F, 8'd0, T, F, F, F, 8'(k), (k == 59), F);
        end
        cyc(0, F, F, F, 8'd0,   T, F, T, F, 8'd0,  F, F);

        // 1..12 wrap: borrow at MIN, clamp below and above, carry at MAX
        cyc(1, T, F, F, 8'd0,   F, F, F, F, 8'd1,  F, F);
        cyc(1, F, F, F, 8'd0,   T, T, F, T, 8'd12, F, F);
        cyc(1, F, F, F, 8'd0,   T, T, F, F, 8'd11, F, F);
        cyc(1, F, F, T, 8'd0,   F, F, F, F, 8'd1,  F, T);
        cyc(1, F, F, F, 8'd0,   F, F, F, F, 8'd1,  F, F);
        cyc(1, F, F, T, 8'd12,  F, F, F, F, 8'd12, T, F);
        cyc(1, F, F, F, 8'd0,   T, F, T, F, 8'd1,  F, F);
        cyc(1, F, F, T, 8'd13,  F, F, F, F, 8'd12, T, T);
        cyc(1, F, F, F, 8'd0,   F, T, F, F, 8'd12, F, F);
        cyc(1, F, F, T, 8'd1,   F, T, F, F, 8'd1,  T, F);

        // 0..23 saturate: hold at both bounds, never strobe
        cyc(2, T, F, F, 8'd0,   F, F, F, F, 8'd0,  F, F);
        cyc(2, F, F, T, 8'd23,  F, F, F, F, 8'd23, T, F);
        for (int k = 0; k < 3; k++) begin
            cyc(2, F, F, F, 8'd0, T, F, F, F, 8'd23, T, F);
        end
        cyc(2, F, F, F, 8'd0,   T, T, F, F, 8'd22, F, F);
        cyc(2, F, T, F, 8'd0,   T, T, F, F, 8'd0,  T, F);
        cyc(2, F, F, F, 8'd0,   T, T, F, F, 8'd0,  T, F);
        cyc(2, F, F, T, 8'd24,  F, F, F, F, 8'd23, T, T);
        cyc(2, F, F, F, 8'd0,   F, F, F, F, 8'd23, T, F);

        rst_v = 3'b000; clr_v = 3'b000; load_v = 3'b000; en_v = 3'b000; dn_v = 3'b000;
        repeat (2) @(posedge CLK);
        #3;
        chk("queue_drain", step_id, 0, comb_q.size() + reg_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
